// File: rtl/sort_pkg.sv
// Constants, colour codes and FSM state type shared by the colour-mean stage
// and the downstream insertion sorter.
package sort_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 16;
    localparam int FRAC  = 16;
    localparam int SUM_W = PIX_W + CNT_W;
    localparam int TOT_W = SUM_W + FRAC;
    localparam int N_IMG = 32;
    localparam int IDX_W = 5;
    localparam int CLR_W = 2;

    localparam logic [CLR_W-1:0] CLR_R = 2'd0;
    localparam logic [CLR_W-1:0] CLR_G = 2'd1;
    localparam logic [CLR_W-1:0] CLR_B = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_SELECT,
        S_DIVIDE,
        S_PRE,
        S_EMIT
    } state_t;

    // Ties go to the lower code, so red beats green beats blue.
    function automatic logic [CLR_W-1:0] dominant(input logic [SUM_W-1:0] r,
                                                  input logic [SUM_W-1:0] g,
                                                  input logic [SUM_W-1:0] b);
        if (r >= g && r >= b)
            return CLR_R;
        else if (g >= b)
            return CLR_G;
        else
            return CLR_B;
    endfunction

endpackage

// File: rtl/serial_div.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, fixed
// DVD_W-cycle latency after start; done is high during the final step.
module serial_div #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(DVD_W);
    localparam logic [CW-1:0] LAST = CW'(DVD_W - 1);

    logic [DVD_W-1:0] shreg;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [CW-1:0]    step;
    logic             running;
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             fits;

    // Remainder stays below the divisor, so it never needs more than DVS_W bits.
    assign trial    = {rem, shreg[DVD_W-1]};
    assign diff     = trial - {1'b0, dvs};
    assign fits     = trial >= {1'b0, dvs};
    assign quotient = shreg;
    assign done     = running && (step == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            rem     <= '0;
            dvs     <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (start) begin
            shreg   <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem   <= fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
            shreg <= {shreg[DVD_W-2:0], fits};
            step  <= step + CW'(1);
            if (step == LAST)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/color_mean_div.sv
// Per-stream colour-mean stage: accumulates channel sums for one image, picks
// the dominant channel, divides its sum by the pixel count and hands the result to the sorter.
module color_mean_div
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    input  logic             img_start,
    input  logic             img_last,
    input  logic [IDX_W-1:0] img_id,
    output logic [CLR_W-1:0] color,
    output logic [TOT_W-1:0] total,
    output logic             in_valid,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             busy,
    output logic             batch_done,
    output logic             err
);

    state_t state, next_state;

    logic [SUM_W-1:0] sum_r, sum_g, sum_b, sum_dom;
    logic [CNT_W-1:0] pix_cnt;
    logic [IDX_W-1:0] cur_id, img_cnt;
    logic [CLR_W-1:0] dom_color, sel_color;
    logic [TOT_W-1:0] quotient;
    logic             div_start, div_done;
    logic             in_frame, take_first, take_add, overflow;

    assign in_frame   = (state == S_IDLE) || (state == S_ACCUM);
    assign take_first = pix_valid && img_start && in_frame;
    assign take_add   = pix_valid && !img_start && (state == S_ACCUM) && (pix_cnt != '1);
    assign overflow   = pix_valid && !img_start && (state == S_ACCUM) && (pix_cnt == '1);

    assign dom_color = dominant(sum_r, sum_g, sum_b);
    always_comb begin
        sum_dom = sum_r;
        case (dom_color)
            CLR_G:   sum_dom = sum_g;
            CLR_B:   sum_dom = sum_b;
            default: sum_dom = sum_r;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        in_valid    = 1'b0;
        index_valid = 1'b0;
        div_start   = 1'b0;
        case (state)
            S_IDLE:
                if (pix_valid && img_start)
                    next_state = img_last ? S_SELECT : S_ACCUM;
            S_ACCUM:
                if (pix_valid && img_last)
                    next_state = S_SELECT;
            S_SELECT: begin
                busy       = 1'b1;
                div_start  = 1'b1;
                next_state = S_DIVIDE;
            end
            S_DIVIDE: begin
                busy = 1'b1;
                if (div_done)
                    next_state = S_PRE;
            end
            S_PRE: begin
                busy        = 1'b1;
                index_valid = 1'b1;
                next_state  = S_EMIT;
            end
            S_EMIT: begin
                busy        = 1'b1;
                index_valid = 1'b1;
                in_valid    = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A start pixel always reloads the sums, which also discards a partial image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            pix_cnt <= '0;
            cur_id  <= '0;
        end else if (take_first) begin
            sum_r   <= SUM_W'(pix_r);
            sum_g   <= SUM_W'(pix_g);
            sum_b   <= SUM_W'(pix_b);
            pix_cnt <= CNT_W'(1);
            cur_id  <= img_id;
        end else if (take_add) begin
            sum_r   <= sum_r + SUM_W'(pix_r);
            sum_g   <= sum_g + SUM_W'(pix_g);
            sum_b   <= sum_b + SUM_W'(pix_b);
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    serial_div #(
        .DVD_W(TOT_W),
        .DVS_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({sum_dom, {FRAC{1'b0}}}),
        .divisor  (pix_cnt),
        .quotient (quotient),
        .done     (div_done)
    );

    // index goes out one cycle ahead of colour/total so the sorter sees it settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_color  <= CLR_R;
            color      <= '0;
            total      <= '0;
            index      <= '0;
            img_cnt    <= '0;
            batch_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == S_SELECT)
                sel_color <= dom_color;
            if (state == S_DIVIDE && div_done)
                index <= cur_id;
            if (state == S_PRE) begin
                color <= sel_color;
                total <= quotient;
            end
            if (state == S_EMIT) begin
                if (img_cnt == IDX_W'(N_IMG - 1)) begin
                    img_cnt    <= '0;
                    batch_done <= 1'b1;
                end else begin
                    img_cnt <= img_cnt + IDX_W'(1);
                end
            end
            if ((pix_valid && busy) || overflow)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_color_mean_div.sv
// [TB] Directed, table-driven bench for color_mean_div: result values, strobe
// latency, busy window, batch completion, dropped pixels and mid-divide reset.
module tb_color_mean_div;
    import sort_pkg::*;

    logic             clk, rst;
    logic             pix_valid, img_start, img_last;
    logic [PIX_W-1:0] pix_r, pix_g, pix_b;
    logic [IDX_W-1:0] img_id;
    logic [CLR_W-1:0] color;
    logic [TOT_W-1:0] total;
    logic             in_valid, index_valid, busy, batch_done, err;
    logic [IDX_W-1:0] index;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int bad_strobe = 0;

    typedef struct {
        int               n;
        logic [3:0]       starts;
        logic [4:0]       first_id;
        logic [4:0]       id;
        logic [3:0][7:0]  r;
        logic [3:0][7:0]  g;
        logic [3:0][7:0]  b;
        logic [1:0]       exp_color;
        logic [39:0]      exp_total;
    } vec_t;

    vec_t vecs[5];

    color_mean_div dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .img_start  (img_start),
        .img_last   (img_last),
        .img_id     (img_id),
        .color      (color),
        .total      (total),
        .in_valid   (in_valid),
        .index      (index),
        .index_valid(index_valid),
        .busy       (busy),
        .batch_done (batch_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_valid) pulses++;
        if (in_valid && !busy) bad_strobe++;
    end

    task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        pix_valid = 1'b0;
        img_start = 1'b0;
        img_last  = 1'b0;
        pix_r     = '0;
        pix_g     = '0;
        pix_b     = '0;
        img_id    = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the idle negedge after EMIT.
    task automatic apply_stimulus(input vec_t v, input bit disturb);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            pix_valid = 1'b1;
            img_start = v.starts[i];
            img_last  = (i == v.n - 1);
            pix_r     = v.r[i];
            pix_g     = v.g[i];
            pix_b     = v.b[i];
            img_id    = (i == 0) ? v.first_id : v.id;
            @(negedge clk);
        end
        drive_idle();
        for (int k = 1; k <= 60 && !seen; k++) begin
            if (k == 1) check_output("busy_select", 40'(busy), 40'd1);
            if (k == 42) begin
                check_output("index_valid_pre", 40'(index_valid), 40'd1);
                check_output("in_valid_pre", 40'(in_valid), 40'd0);
                check_output("index_pre", 40'(index), 40'(v.id));
            end
            if (in_valid) begin
                seen = 1'b1;
                check_output("latency", 40'(k), 40'd43);
                check_output("color", 40'(color), 40'(v.exp_color));
                check_output("total", total, v.exp_total);
                check_output("index", 40'(index), 40'(v.id));
                check_output("index_valid_emit", 40'(index_valid), 40'd1);
                check_output("busy_emit", 40'(busy), 40'd1);
            end else begin
                if (disturb && k >= 5 && k <= 7) begin
                    pix_valid = 1'b1;
                    img_start = 1'b1;
                    img_last  = 1'b1;
                    pix_b     = 8'd255;
                    img_id    = 5'd7;
                end else begin
                    drive_idle();
                end
                @(negedge clk);
            end
        end
        check_output("emit_seen", 40'(seen), 40'd1);
        @(negedge clk);
        check_output("in_valid_after", 40'(in_valid), 40'd0);
        check_output("busy_after", 40'(busy), 40'd0);
    endtask

    initial begin
        vec_t bv;
        int   dom;
        int   p0;

        vecs[0] = '{n:1, starts:4'b0001, first_id:5'd5, id:5'd5,
                    r:{8'd0, 8'd0, 8'd0, 8'd200}, g:{8'd0, 8'd0, 8'd0, 8'd10},
                    b:{8'd0, 8'd0, 8'd0, 8'd10}, exp_color:2'd0, exp_total:40'd13107200};
        vecs[1] = '{n:4, starts:4'b0001, first_id:5'd9, id:5'd9,
                    r:32'd0, g:{8'd100, 8'd100, 8'd100, 8'd100},
                    b:32'd0, exp_color:2'd1, exp_total:40'd6553600};
        vecs[2] = '{n:3, starts:4'b0001, first_id:5'd17, id:5'd17,
                    r:32'd0, g:32'd0, b:{8'd0, 8'd2, 8'd1, 8'd1},
                    exp_color:2'd2, exp_total:40'd87381};
        vecs[3] = '{n:2, starts:4'b0001, first_id:5'd30, id:5'd30,
                    r:{8'd0, 8'd0, 8'd50, 8'd50}, g:{8'd0, 8'd0, 8'd50, 8'd50},
                    b:32'd0, exp_color:2'd0, exp_total:40'd3276800};
        vecs[4] = '{n:4, starts:4'b0101, first_id:5'd3, id:5'd12,
                    r:{8'd0, 8'd0, 8'd255, 8'd255}, g:32'd0,
                    b:{8'd20, 8'd40, 8'd0, 8'd0}, exp_color:2'd2, exp_total:40'd1966080};

        do_reset();
        check_output("rst_color", 40'(color), 40'd0);
        check_output("rst_total", total, 40'd0);
        check_output("rst_index", 40'(index), 40'd0);
        check_output("rst_in_valid", 40'(in_valid), 40'd0);
        check_output("rst_index_valid", 40'(index_valid), 40'd0);
        check_output("rst_busy", 40'(busy), 40'd0);
        check_output("rst_batch_done", 40'(batch_done), 40'd0);
        check_output("rst_err", 40'(err), 40'd0);

        p0 = pulses;
        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], 1'b0);
        check_output("table_pulses", 40'(pulses - p0), 40'd5);
        check_output("table_err", 40'(err), 40'd0);

        $display("[TB] batch of %0d images", N_IMG);
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 32; i++) begin
            bv.n        = 1;
            bv.starts   = 4'b0001;
            bv.first_id = 5'(i);
            bv.id       = 5'(i);
            bv.r        = 32'd10;
            bv.g        = 32'd20;
            bv.b        = 32'(i * 8);
            dom          = (i * 8 > 20) ? i * 8 : 20;
            bv.exp_color = (i * 8 > 20) ? 2'd2 : 2'd1;
            bv.exp_total = 40'(dom) << 16;
            apply_stimulus(bv, 1'b0);
            if (i == 30) check_output("batch_done_early", 40'(batch_done), 40'd0);
        end
        check_output("batch_pulses", 40'(pulses - p0), 40'd32);
        check_output("batch_done", 40'(batch_done), 40'd1);
        check_output("strobe_while_idle", 40'(bad_strobe), 40'd0);

        apply_stimulus(vecs[0], 1'b1);
        check_output("err_dropped_pixel", 40'(err), 40'd1);

        pix_valid = 1'b1;
        img_start = 1'b1;
        img_last  = 1'b1;
        pix_r     = 8'd100;
        img_id    = 5'd21;
        @(negedge clk);
        drive_idle();
        repeat (10) @(negedge clk);
        p0 = pulses;
        rst = 1'b0;
        #1;
        check_output("mid_rst_color", 40'(color), 40'd0);
        check_output("mid_rst_total", total, 40'd0);
        check_output("mid_rst_index", 40'(index), 40'd0);
        check_output("mid_rst_in_valid", 40'(in_valid), 40'd0);
        check_output("mid_rst_index_valid", 40'(index_valid), 40'd0);
        check_output("mid_rst_busy", 40'(busy), 40'd0);
        check_output("mid_rst_batch_done", 40'(batch_done), 40'd0);
        check_output("mid_rst_err", 40'(err), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check_output("no_emit_after_rst", 40'(pulses - p0), 40'd0);
        apply_stimulus(vecs[1], 1'b0);
        check_output("err_after_rst", 40'(err), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
